// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract of two WIDTH-bit operands, CHUNK bits per clock; result valid N+1 cycles after accept.
// No pipelining: in_ready drops until the registered result is consumed; outputs hold while out_ready is low.
module chunked_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_adder: illegal WIDTH/CHUNK combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;
  logic             r_overflow;

  logic [31:0]      w_base;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK:0]   w_ext;
  logic             w_ovf;

  assign w_base = 32'(r_cnt) * 32'(CHUNK);
  assign w_ca   = r_a[w_base +: CHUNK];
  assign w_cb   = r_b[w_base +: CHUNK];
  assign w_ext  = {1'b0, w_ca} + {1'b0, w_cb} + (CHUNK+1)'(r_carry);
  // Same-sign operands producing an opposite-sign MSB equals carry-in(MSB) XOR carry-out(MSB).
  assign w_ovf  = (w_ca[CHUNK-1] == w_cb[CHUNK-1]) && (w_ext[CHUNK-1] != w_ca[CHUNK-1]);

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= carry_in ^ sub;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc[w_base +: CHUNK] <= w_ext[CHUNK-1:0];
          r_carry                <= w_ext[CHUNK];
          r_cnt                  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_ovf   <= w_ovf;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // First DONE cycle registers the result; afterwards wait for the consumer.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_sum       <= r_acc;
            r_carry_out <= r_carry;
            r_overflow  <= r_ovf;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder: 8-bit/2-bit-chunk instance plus a 1-bit instance.
module tb_chunked_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, co8, ov8, busy8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, co1, ov1, busy1;
  logic [0:0] a1, b1, sum1;

  chunked_adder #(.WIDTH(8), .CHUNK(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .carry_in(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .carry_out(co8), .overflow(ov8), .busy(busy8));

  chunked_adder #(.WIDTH(1), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .carry_in(cin1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .carry_out(co1), .overflow(ov1), .busy(busy1));

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    string      n;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        n_total++;
        $display("FAIL w8_unexpected_output: got sum 0x%0h with no pending op", sum8);
      end else begin
        e = q8.pop_front();
        check({e.n, "_sum"}, 32'(sum8), 32'(e.s));
        check({e.n, "_cout"}, 32'(co8), 32'(e.c));
        check({e.n, "_ovf"}, 32'(ov8), 32'(e.v));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL w1_unexpected_output: got sum %0d with no pending op", sum1);
      end else begin
        e = q1.pop_front();
        check({e.n, "_sum"}, 32'(sum1), 32'(e.s));
        check({e.n, "_cout"}, 32'(co1), 32'(e.c));
        check({e.n, "_ovf"}, 32'(ov1), 32'(e.v));
      end
    end
  end

  task automatic send8(input logic [7:0] pa, input logic [7:0] pb, input logic pc, input logic ps,
                       input logic [7:0] es, input logic ec, input logic ev, input string nm,
                       input bit push);
    int guard = 0;
    a8 = pa; b8 = pb; cin8 = pc; sub8 = ps; in_valid8 = 1'b1;
    @(negedge clk);
    while (!in_ready8 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check({nm, "_accepted"}, 32'(in_ready8), 32'd1);
    @(posedge clk);
    if (push) q8.push_back('{s: es, c: ec, v: ev, n: nm});
    #1 in_valid8 = 1'b0;
  endtask

  task automatic send1(input logic pa, input logic pb, input logic pc, input logic ps,
                       input logic es, input logic ec, input logic ev, input string nm);
    int guard = 0;
    a1 = pa; b1 = pb; cin1 = pc; sub1 = ps; in_valid1 = 1'b1;
    @(negedge clk);
    while (!in_ready1 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check({nm, "_accepted"}, 32'(in_ready1), 32'd1);
    @(posedge clk);
    q1.push_back('{s: {7'd0, es}, c: ec, v: ev, n: nm});
    #1 in_valid1 = 1'b0;
  endtask

  // Counts accept-relative edges until out_valid is seen; called right after send.
  task automatic wait_valid8(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid8 && lat < 40);
  endtask

  task automatic wait_valid1(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid1 && lat < 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    rst = 1'b1;
    in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
    in_valid1 = 1'b1; a1 = 1'b1;  b1 = 1'b0;  cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;

    // Reset with in_valid asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready8), 32'd0);
    check("rst_out_valid", 32'(out_valid8), 32'd0);
    check("rst_sum", 32'(sum8), 32'h00);
    check("rst_cout", 32'(co8), 32'd0);
    check("rst_ovf", 32'(ov8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_w1_out_valid", 32'(out_valid1), 32'd0);
    step();
    rst = 1'b0; in_valid8 = 1'b0; in_valid1 = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready8), 32'd1);

    // Unsigned wrap and latency
    step();
    send8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "wrap", 1'b1);
    wait_valid8(lat);
    check("wrap_latency", 32'(lat), 32'd5);

    // Signed overflow, subtract, borrow chains
    send8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "ovf_pos", 1'b1);
    send8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "ovf_neg", 1'b1);
    send8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_borrow", 1'b1);
    send8(8'h20, 8'h10, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, "sub_bin", 1'b1);
    send8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf", 1'b1);
    send8(8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "cin_ripple", 1'b1);
    wait_valid8(lat);
    step();

    // Backpressure and ignored in_valid while busy
    out_ready8 = 1'b0;
    send8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, "bp", 1'b1);
    step();
    in_valid8 = 1'b1; a8 = 8'h55; b8 = 8'h55; sub8 = 1'b1;
    @(negedge clk);
    check("busy_in_ready", 32'(in_ready8), 32'd0);
    check("busy_flag", 32'(busy8), 32'd1);
    step();
    in_valid8 = 1'b0;
    wait_valid8(lat);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_hold_sum", 32'(sum8), 32'h46);
      check("bp_hold_valid", 32'(out_valid8), 32'd1);
      check("bp_in_ready", 32'(in_ready8), 32'd0);
    end
    step();
    out_ready8 = 1'b1;
    step();
    @(negedge clk);
    check("consumed_valid", 32'(out_valid8), 32'd0);
    check("consumed_in_ready", 32'(in_ready8), 32'd1);
    check("consumed_sum_hold", 32'(sum8), 32'h46);
    step();
    send8(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, "after_bp", 1'b1);
    wait_valid8(lat);
    step();

    // New operands offered in the same cycle the result is consumed
    out_ready8 = 1'b0;
    send8(8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "done_hold", 1'b1);
    wait_valid8(lat);
    step();
    out_ready8 = 1'b1;
    in_valid8 = 1'b1; a8 = 8'hC0; b8 = 8'hC0; cin8 = 1'b0; sub8 = 1'b0;
    @(negedge clk);
    check("done_no_accept", 32'(in_ready8), 32'd0);
    send8(8'hC0, 8'hC0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, "next_op", 1'b1);
    wait_valid8(lat);
    step();

    // Reset while BUSY with count==2 aborts the operation
    send8(8'hAA, 8'h11, 1'b0, 1'b0, 8'hBB, 1'b0, 1'b0, "aborted", 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_in_ready", 32'(in_ready8), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid8) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_output", 32'(seen), 32'd0);
    step();
    send8(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, "post_abort", 1'b1);
    wait_valid8(lat);
    step();

    // 1-bit instance behaves as a registered full adder
    send1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "w1_fa111");
    wait_valid1(lat);
    check("w1_latency", 32'(lat), 32'd2);
    send1(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "w1_fa100");
    send1(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "w1_sub");
    wait_valid1(lat);
    repeat (3) step();

    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
